// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_rx
// Brief    : SPI mode-0 receive front end assembling {read_write, addr, data}
//            frames with burst auto-increment and truncation detection.
//            Define SPI_RX_PARITY_EN for a trailing even-parity bit per word.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_rx #(
   parameter int CDC_LEN  = 2,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int AUTO_INC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              copi,
   input  logic              n_cs,
   output logic              read_write,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              frame_err,
   output logic              parity_err
);

`ifdef SPI_RX_PARITY_EN
   localparam int c_PAR_W = 1;
`else
   localparam int c_PAR_W = 0;
`endif
   localparam int c_FRAME_W = 1 + ADDR_W + DATA_W + c_PAR_W;
   localparam int c_WORD_W  = DATA_W + c_PAR_W;
   localparam int c_CNT_W   = $clog2(2 + ADDR_W + DATA_W);
   localparam logic [c_CNT_W-1:0] c_HDR_LAST  = c_CNT_W'(c_FRAME_W - 1);
   localparam logic [c_CNT_W-1:0] c_WORD_LAST = c_CNT_W'(c_WORD_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HDR   = 2'd1,
      S_BURST = 2'd2
   } state_t;

   state_t                 r_state;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [c_FRAME_W-2:0]   r_shift;
   logic [CDC_LEN:0]       r_sclk_sync;
   logic [CDC_LEN-1:0]     r_copi_sync;
   logic [CDC_LEN-1:0]     r_ncs_sync;
   logic [CDC_LEN-1:0]     r_flush;
   logic                   r_armed;

   logic                   w_rise;
   logic                   w_ncs;
   logic                   w_copi;
   logic [c_FRAME_W-1:0]   w_word;
   logic                   w_hdr_par_ok;
   logic                   w_brst_par_ok;

   // r_armed only sets once a real deselect has travelled the synchroniser
   // after reset, so a frame interrupted by reset is never resumed mid-way.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_copi_sync <= '0;
         r_ncs_sync  <= '1;
         r_flush     <= '0;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[CDC_LEN-1:0], sclk};
         r_copi_sync <= {r_copi_sync[CDC_LEN-2:0], copi};
         r_ncs_sync  <= {r_ncs_sync[CDC_LEN-2:0], n_cs};
         r_flush     <= {r_flush[CDC_LEN-2:0], 1'b1};
         if (r_flush[CDC_LEN-1] && w_ncs) r_armed <= 1'b1;
      end
   end

   assign w_rise = r_sclk_sync[CDC_LEN-1] & ~r_sclk_sync[CDC_LEN];
   assign w_ncs  = r_ncs_sync[CDC_LEN-1];
   assign w_copi = r_copi_sync[CDC_LEN-1];
   assign w_word = {r_shift, w_copi};

`ifdef SPI_RX_PARITY_EN
   assign w_hdr_par_ok  = ~^w_word;
   assign w_brst_par_ok = ~^w_word[c_WORD_W-1:0];
`else
   assign w_hdr_par_ok  = 1'b1;
   assign w_brst_par_ok = 1'b1;
   assign parity_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         read_write <= 1'b0;
         addr       <= '0;
         data       <= '0;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
`ifdef SPI_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef SPI_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (w_ncs) begin
            // Deselect overrides a coincident sclk edge.
            if (r_state != S_IDLE && r_cnt != '0) frame_err <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (r_armed) begin
                     r_state <= S_HDR;
                     r_cnt   <= '0;
                  end
               end
               S_HDR: begin
                  if (w_rise) begin
                     r_shift <= w_word[c_FRAME_W-2:0];
                     if (r_cnt == c_HDR_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_BURST;
                        if (w_hdr_par_ok) begin
                           read_write <= w_word[c_FRAME_W-1];
                           addr       <= w_word[c_PAR_W+DATA_W +: ADDR_W];
                           data       <= w_word[c_PAR_W +: DATA_W];
                           valid      <= 1'b1;
                        end
`ifdef SPI_RX_PARITY_EN
                        else parity_err <= 1'b1;
`endif
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               S_BURST: begin
                  if (w_rise) begin
                     r_shift <= w_word[c_FRAME_W-2:0];
                     if (r_cnt == c_WORD_LAST) begin
                        r_cnt <= '0;
                        if (AUTO_INC != 0) begin
                           addr <= addr + 1'b1;
                           if (w_brst_par_ok) begin
                              data  <= w_word[c_PAR_W +: DATA_W];
                              valid <= 1'b1;
                           end
`ifdef SPI_RX_PARITY_EN
                           else parity_err <= 1'b1;
`endif
                        end
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
`default_nettype none
// tb_spi_frame_rx: AUTO_INC=1 and AUTO_INC=0 instances share one SPI stimulus;
// table-driven frames plus hand sequences for latency, reset and parity.
module tb_spi_frame_rx;
   localparam int HALF = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic copi = 1'b0;
   logic n_cs = 1'b1;

   logic       a_rw, a_valid, a_fe, a_pe;
   logic [6:0] a_addr;
   logic [7:0] a_data;
   logic       b_rw, b_valid, b_fe, b_pe;
   logic [6:0] b_addr;
   logic [7:0] b_data;

   always #5 clk = ~clk;

   spi_frame_rx #(.CDC_LEN(2), .ADDR_W(7), .DATA_W(8), .AUTO_INC(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .n_cs(n_cs),
      .read_write(a_rw), .addr(a_addr), .data(a_data),
      .valid(a_valid), .frame_err(a_fe), .parity_err(a_pe)
   );

   spi_frame_rx #(.CDC_LEN(2), .ADDR_W(7), .DATA_W(8), .AUTO_INC(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .n_cs(n_cs),
      .read_write(b_rw), .addr(b_addr), .data(b_data),
      .valid(b_valid), .frame_err(b_fe), .parity_err(b_pe)
   );

   typedef struct {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] dat;
      int         nhdr;
      int         nb;
      logic [7:0] b0;
      logic [7:0] b1;
      int         extra;
      int         a_nv;
      logic       e_rw;
      logic [6:0] a_addr;
      logic [7:0] a_dat;
      int         a_fe;
      logic [15:0] ev0;
      logic [15:0] ev1;
      logic [15:0] ev2;
      int         b_nv;
      logic [6:0] b_addr;
      logic [7:0] b_dat;
      int         b_fe;
      logic       flip;
   } vec_t;

   vec_t vecs[6];
   int checks = 0;
   int errors = 0;

   // Event monitor: counts pulses and records AUTO_INC=1 valid words.
   int a_nv_cnt = 0, a_fe_cnt = 0, b_nv_cnt = 0, b_fe_cnt = 0, pe_cnt = 0, viol = 0;
   logic [15:0] aq[$];
   logic a_pv = 1'b0, a_pf = 1'b0, b_pv = 1'b0, b_pf = 1'b0;

   always @(negedge clk) begin
      if (a_valid) begin
         aq.push_back({a_rw, a_addr, a_data});
         a_nv_cnt++;
      end
      if (a_fe) a_fe_cnt++;
      if (b_valid) b_nv_cnt++;
      if (b_fe) b_fe_cnt++;
      if (a_pe) pe_cnt++;
      if (b_pe) pe_cnt++;
      if ((a_valid && a_fe) || (b_valid && b_fe) || (a_valid && a_pv) || (a_fe && a_pf) ||
          (b_valid && b_pv) || (b_fe && b_pf)) viol++;
      a_pv = a_valid; a_pf = a_fe; b_pv = b_valid; b_pf = b_fe;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      copi = b;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [15:0] hdr;
      logic [7:0]  bw;
      hdr = {v.rw, v.addr, v.dat};
      @(negedge clk);
      n_cs = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < v.nhdr; i++) send_bit(hdr[15-i]);
`ifdef SPI_RX_PARITY_EN
      if (v.nhdr == 16) send_bit((^hdr) ^ v.flip);
`endif
      for (int j = 0; j < v.nb; j++) begin
         bw = (j == 0) ? v.b0 : v.b1;
         for (int k = 7; k >= 0; k--) send_bit(bw[k]);
`ifdef SPI_RX_PARITY_EN
         send_bit(^bw);
`endif
      end
      for (int e = 0; e < v.extra; e++) send_bit(e[0]);
      repeat (HALF) @(negedge clk);
      n_cs = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, af0, b0, bf0, p0, qb;
      logic [15:0] fr;
      vecs[0] = '{1'b1, 7'h05, 8'hA5, 16, 0, 8'h00, 8'h00, 0,
                  1, 1'b1, 7'h05, 8'hA5, 0, {1'b1, 7'h05, 8'hA5}, 16'h0, 16'h0,
                  1, 7'h05, 8'hA5, 0, 1'b0};
      vecs[1] = '{1'b0, 7'h10, 8'h3C, 16, 0, 8'h00, 8'h00, 0,
                  1, 1'b0, 7'h10, 8'h3C, 0, {1'b0, 7'h10, 8'h3C}, 16'h0, 16'h0,
                  1, 7'h10, 8'h3C, 0, 1'b0};
      vecs[2] = '{1'b1, 7'h55, 8'h00, 10, 0, 8'h00, 8'h00, 0,
                  0, 1'b0, 7'h10, 8'h3C, 1, 16'h0, 16'h0, 16'h0,
                  0, 7'h10, 8'h3C, 1, 1'b0};
      vecs[3] = '{1'b1, 7'h7F, 8'h11, 16, 2, 8'h22, 8'h33, 0,
                  3, 1'b1, 7'h01, 8'h33, 0, {1'b1, 7'h7F, 8'h11}, {1'b1, 7'h00, 8'h22},
                  {1'b1, 7'h01, 8'h33}, 1, 7'h7F, 8'h11, 0, 1'b0};
      vecs[4] = '{1'b0, 7'h03, 8'h44, 16, 1, 8'h55, 8'h00, 3,
                  2, 1'b0, 7'h04, 8'h55, 1, {1'b0, 7'h03, 8'h44}, {1'b0, 7'h04, 8'h55},
                  16'h0, 1, 7'h03, 8'h44, 1, 1'b0};
      vecs[5] = '{1'b0, 7'h00, 8'h01, 16, 1, 8'hFE, 8'h00, 0,
                  2, 1'b0, 7'h01, 8'hFE, 0, {1'b0, 7'h00, 8'h01}, {1'b0, 7'h01, 8'hFE},
                  16'h0, 1, 7'h00, 8'h01, 0, 1'b0};

      repeat (4) @(negedge clk);
      check("reset_rw", 32'(a_rw), 32'h0);
      check("reset_addr", 32'(a_addr), 32'h0);
      check("reset_data", 32'(a_data), 32'h0);
      check("reset_pulses", 32'({a_valid, a_fe, a_pe, b_valid, b_fe, b_pe}), 32'h0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         a0 = a_nv_cnt; af0 = a_fe_cnt; b0 = b_nv_cnt; bf0 = b_fe_cnt; qb = aq.size();
         run_vec(vecs[i]);
         check($sformatf("v%0d_a_nvalid", i), 32'(a_nv_cnt - a0), 32'(vecs[i].a_nv));
         check($sformatf("v%0d_a_ferr", i), 32'(a_fe_cnt - af0), 32'(vecs[i].a_fe));
         check($sformatf("v%0d_a_rw", i), 32'(a_rw), 32'(vecs[i].e_rw));
         check($sformatf("v%0d_a_addr", i), 32'(a_addr), 32'(vecs[i].a_addr));
         check($sformatf("v%0d_a_data", i), 32'(a_data), 32'(vecs[i].a_dat));
         if (vecs[i].a_nv > 0) check($sformatf("v%0d_a_ev0", i), 32'(aq[qb]), 32'(vecs[i].ev0));
         if (vecs[i].a_nv > 1) check($sformatf("v%0d_a_ev1", i), 32'(aq[qb+1]), 32'(vecs[i].ev1));
         if (vecs[i].a_nv > 2) check($sformatf("v%0d_a_ev2", i), 32'(aq[qb+2]), 32'(vecs[i].ev2));
         check($sformatf("v%0d_b_nvalid", i), 32'(b_nv_cnt - b0), 32'(vecs[i].b_nv));
         check($sformatf("v%0d_b_ferr", i), 32'(b_fe_cnt - bf0), 32'(vecs[i].b_fe));
         check($sformatf("v%0d_b_rw", i), 32'(b_rw), 32'(vecs[i].e_rw));
         check($sformatf("v%0d_b_addr", i), 32'(b_addr), 32'(vecs[i].b_addr));
         check($sformatf("v%0d_b_data", i), 32'(b_data), 32'(vecs[i].b_dat));
      end

      // Latency: valid must appear exactly on clk edge CDC_LEN+1 = 3.
      fr = {1'b1, 7'h05, 8'hA5};
      @(negedge clk);
      n_cs = 1'b0;
      repeat (2) @(negedge clk);
`ifdef SPI_RX_PARITY_EN
      for (int i = 15; i >= 0; i--) send_bit(fr[i]);
      @(negedge clk);
      copi = ^fr;
`else
      for (int i = 15; i >= 1; i--) send_bit(fr[i]);
      @(negedge clk);
      copi = fr[0];
`endif
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      check("lat_edge2_valid", 32'(a_valid), 32'h0);
      @(negedge clk);
      check("lat_edge3_valid", 32'(a_valid), 32'h1);
      check("lat_edge3_data", 32'(a_data), 32'hA5);
      repeat (HALF - 3) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      n_cs = 1'b1;
      repeat (10) @(negedge clk);

      // Reset after 6 header bits, remainder of that frame must be ignored.
      fr = {1'b0, 7'h7E, 8'h81};
      @(negedge clk);
      n_cs = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 15; i >= 10; i--) send_bit(fr[i]);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_mid_rw", 32'(a_rw), 32'h0);
      check("rst_mid_addr", 32'(a_addr), 32'h0);
      check("rst_mid_data", 32'(a_data), 32'h0);
      a0 = a_nv_cnt; af0 = a_fe_cnt;
      for (int i = 9; i >= 0; i--) send_bit(fr[i]);
      repeat (HALF) @(negedge clk);
      n_cs = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_tail_nvalid", 32'(a_nv_cnt - a0), 32'h0);
      check("rst_tail_ferr", 32'(a_fe_cnt - af0), 32'h0);
      a0 = a_nv_cnt;
      run_vec('{1'b1, 7'h02, 8'hFF, 16, 0, 8'h00, 8'h00, 0, 0, 1'b0, 7'h0, 8'h0, 0,
                16'h0, 16'h0, 16'h0, 0, 7'h0, 8'h0, 0, 1'b0});
      check("post_rst_nvalid", 32'(a_nv_cnt - a0), 32'h1);
      check("post_rst_rw", 32'(a_rw), 32'h1);
      check("post_rst_addr", 32'(a_addr), 32'h02);
      check("post_rst_data", 32'(a_data), 32'hFF);

`ifdef SPI_RX_PARITY_EN
      a0 = a_nv_cnt; p0 = pe_cnt;
      vecs[0].flip = 1'b1;
      run_vec(vecs[0]);
      check("par_bad_nvalid", 32'(a_nv_cnt - a0), 32'h0);
      check("par_bad_perr", 32'(pe_cnt - p0), 32'h2);
      check("par_bad_addr_kept", 32'(a_addr), 32'h02);
      check("par_bad_data_kept", 32'(a_data), 32'hFF);
      a0 = a_nv_cnt; p0 = pe_cnt;
      vecs[0].flip = 1'b0;
      run_vec(vecs[0]);
      check("par_ok_nvalid", 32'(a_nv_cnt - a0), 32'h1);
      check("par_ok_perr", 32'(pe_cnt - p0), 32'h0);
      check("par_ok_data", 32'(a_data), 32'hA5);
`else
      p0 = 0;
      check("parity_err_tied", 32'(pe_cnt - p0), 32'h0);
`endif
      check("pulse_rules", 32'(viol), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
